// File: rtl/singly_linked_list_walker_if.sv
// rtl/singly_linked_list_walker_if.sv - node beat stream between the list walker and its consumer
interface singly_linked_list_walker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8
);
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1);

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_addr,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_addr,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/singly_linked_list_walker.sv
// rtl/singly_linked_list_walker.sv - walks a singly linked list and streams {addr, data} beats; LL_WALKER_CHECK_EN adds chain checks
module singly_linked_list_walker #(
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_NODE   = 8,
    parameter int  TIMEOUT    = 15,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [2:0]            ll_op,
    output logic [ADDR_WIDTH-1:0] ll_addr,
    output logic                  ll_op_start,
    input  logic                  ll_op_done,
    input  logic                  ll_fault,
    input  logic [DATA_WIDTH-1:0] ll_data_out,
    input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
    input  logic [ADDR_WIDTH-1:0] ll_head,
    input  logic [ADDR_WIDTH-1:0] ll_length,
    singly_linked_list_walker_if.master m
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BEAT, S_FINISH} state_t;

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
`ifdef LL_WALKER_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE + 1);
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic                  op_start_q, op_start_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic                  m_last_q, m_last_d;
    logic [ADDR_WIDTH-1:0] len_m1;

    // len_q is at least 1 whenever REQ/BEAT use len_m1, so no underflow is observed
    assign len_m1 = len_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        nxt_d      = nxt_q;
        count_d    = count_q;
        tmo_d      = tmo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        op_start_d = op_start_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_addr_d   = m_addr_q;
        m_last_d   = m_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = ll_length;
                    addr_d  = ll_head;
                    count_d = '0;
                    tmo_d   = '0;
                    if (ll_length == '0) begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        busy_d     = 1'b1;
                        op_start_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (ll_op_done) begin
                    op_start_d = 1'b0;
                    if (ll_fault) begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d   = S_BEAT;
                        m_valid_d = 1'b1;
                        m_data_d  = ll_data_out;
                        m_addr_d  = addr_q;
                        nxt_d     = ll_next_node_addr;
`ifdef LL_WALKER_CHECK_EN
                        // a NULL pointer before the expected end truncates the walk here
                        m_last_d  = (count_q == len_m1) || (ll_next_node_addr == ADDR_NULL);
`else
                        m_last_d  = (count_q == len_m1);
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = S_FINISH;
                    op_start_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    fault_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BEAT: begin
                if (m.m_ready) begin
                    count_d   = count_q + 1'b1;
                    addr_d    = nxt_q;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`ifdef LL_WALKER_CHECK_EN
                        // last beat must both be the counted end and point at NULL
                        fault_d = (nxt_q != ADDR_NULL) || (count_q != len_m1);
`endif
                    end else begin
                        state_d    = S_REQ;
                        op_start_d = 1'b1;
                        tmo_d      = '0;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            nxt_q      <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            op_start_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_addr_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            nxt_q      <= nxt_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            op_start_q <= op_start_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_addr_q   <= m_addr_d;
            m_last_q   <= m_last_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign count       = count_q;
    assign ll_op       = 3'd0;
    assign ll_addr     = addr_q;
    assign ll_op_start = op_start_q;
    assign m.m_valid   = m_valid_q;
    assign m.m_data    = m_data_q;
    assign m.m_addr    = m_addr_q;
    assign m.m_last    = m_last_q;
endmodule
